// File: rtl/src_sel_pkg.sv
// rtl/src_sel_pkg.sv - shared select codes and extension mode for the source-select stage
package src_sel_pkg;

    localparam int SRC_REG = 0;
    localparam int SRC_IMM = 1;
    localparam int SRC_FWD = 2;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_mode_e;

endpackage

// File: rtl/stage_fifo2.sv
// rtl/stage_fifo2.sv - two-entry output buffer with registered ready/valid flags
module stage_fifo2 #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic [1:0]    occ;
    logic [1:0]    occ_next;
    logic          push;
    logic          pop;

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = head;

    // Next occupancy from this cycle's push/pop pair
    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 2'd1;
        end else if (pop && !push) begin
            occ_next = occ - 2'd1;
        end
    end

    // Occupancy and flags; flags come from registers so out_ready never reaches in_ready combinationally
    // in_ready stays low during reset and rises on the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            occ       <= occ_next;
            in_ready  <= (occ_next < 2'd2);
            out_valid <= (occ_next != 2'd0);
        end
    end

    // Entry storage: head is what the consumer sees, tail only fills at occupancy 1 without a pop
    // head is left untouched when the buffer empties so out_data holds its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
                head <= in_data;
            end else if (pop && occ == 2'd2) begin
                head <= tail;
            end
            if (push && occ == 2'd1 && !pop) begin
                tail <= in_data;
            end
        end
    end

endmodule

// File: rtl/src_sel_stage.sv
// rtl/src_sel_stage.sv - operand source select with immediate extension and buffered output
module src_sel_stage
    import src_sel_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_SRC = 3,
    parameter  int IMM_W   = 4,
    localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*WIDTH-1:0] in_src,
    input  logic [IMM_W-1:0]         in_imm,
    input  logic                     in_ext_mode,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               err_count
);

    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept;
    logic [WIDTH:0]   fifo_out;

    generate
        if (IMM_W == WIDTH) begin : g_imm_full
            assign imm_ext = in_imm;
        end else begin : g_imm_ext
            logic fill;
            assign fill    = (ext_mode_e'(in_ext_mode) == EXT_SIGN) && in_imm[IMM_W-1];
            assign imm_ext = {{(WIDTH-IMM_W){fill}}, in_imm};
        end
    endgenerate

    // Select decode: immediate code wins, other legal codes pick a source, the rest flag an error
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b0;
        if (int'(in_sel) == SRC_IMM) begin
            sel_data = imm_ext;
        end else if (int'(in_sel) < NUM_SRC) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (int'(in_sel) == k) begin
                    sel_data = in_src[k*WIDTH +: WIDTH];
                end
            end
        end else begin
            sel_err = 1'b1;
        end
    end

    assign accept = in_valid && in_ready;

    stage_fifo2 #(
        .DW (WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   ({sel_err, sel_data}),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (fifo_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_err  = fifo_out[WIDTH];
    assign out_data = fifo_out[WIDTH-1:0];

    // Saturating count of accepted illegal selects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (accept && sel_err && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_src_sel_stage.sv
// tb/tb_src_sel_stage.sv - randomized scoreboard bench for src_sel_stage
module tb_src_sel_stage;

    localparam int WIDTH   = 8;
    localparam int NUM_SRC = 3;
    localparam int IMM_W   = 4;
    localparam int SEL_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_SRC*WIDTH-1:0] in_src;
    logic [IMM_W-1:0]         in_imm;
    logic                     in_ext_mode;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_err;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               err_count;

    src_sel_stage #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .IMM_W(IMM_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_src      (in_src),
        .in_imm      (in_imm),
        .in_ext_mode (in_ext_mode),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_err     (out_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int             checks = 0;
    int             errors = 0;
    logic [WIDTH:0] exp_q[$];
    int             exp_errs = 0;
    bit             mon_en = 1'b0;
    bit             last_acc;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: {err, data} from the selection rules with plain arithmetic
    function automatic logic [WIDTH:0] ref_model(input int sel, input int imm, input bit mode,
                                                 input logic [NUM_SRC*WIDTH-1:0] src);
        int v;
        logic [NUM_SRC*WIDTH-1:0] t;
        if (sel == 1) begin
            v = imm;
            if (mode && imm >= (1 << (IMM_W - 1))) v = v + (1 << WIDTH) - (1 << IMM_W);
            return {1'b0, WIDTH'(v)};
        end
        if (sel < NUM_SRC) begin
            t = src >> (sel * WIDTH);
            return {1'b0, t[WIDTH-1:0]};
        end
        return {1'b1, {WIDTH{1'b0}}};
    endfunction

    // One stimulus cycle: drive at negedge, record the accepted entry after the edge
    task automatic cycle(input bit v, input int sel, input int imm, input bit mode,
                         input logic [NUM_SRC*WIDTH-1:0] src, input bit rdy, input int exp_const = -1);
        bit acc;
        logic [WIDTH:0] e;
        @(negedge clk);
        in_valid    = v;
        in_sel      = SEL_W'(sel);
        in_imm      = IMM_W'(imm);
        in_ext_mode = mode;
        in_src      = src;
        out_ready   = rdy;
        acc = v && in_ready;
        e   = ref_model(sel, imm, mode, src);
        @(posedge clk);
        #1;
        if (acc) begin
            if (exp_q.size() == 0) begin
                check("latency_valid", out_valid, 1);
                check("latency_entry", {out_err, out_data}, e);
                if (exp_const >= 0) check("directed_data", out_data, exp_const);
            end
            exp_q.push_back(e);
            if (e[WIDTH] && exp_errs < 255) exp_errs++;
        end
        last_acc = acc;
    endtask

    // Monitor: flags track model occupancy; head is compared every valid cycle and popped on handshake
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("out_valid", out_valid, exp_q.size() > 0);
                check("in_ready", in_ready, exp_q.size() < 2);
                check("err_count", err_count, exp_errs);
                if (out_valid && exp_q.size() > 0) begin
                    check("head_entry", {out_err, out_data}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bit got;
        rst_n = 1'b0; in_valid = 1'b0; in_src = '0; in_imm = '0;
        in_ext_mode = 1'b0; in_sel = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_count", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1 check("ready_after_edge", in_ready, 1);
        mon_en = 1'b1;

        cycle(1, 0, 0, 0, 24'h00005A, 1, 'h5A);
        cycle(1, 1, 4'b1010, 1, 24'h0, 1, 'hFA);
        cycle(1, 1, 4'b1010, 0, 24'h0, 1, 'h0A);
        cycle(1, 3, 0, 0, 24'h0, 1, 'h00);
        check("err_count_one", err_count, 1);
        for (int i = 0; i < 300; i++) cycle(1, 3, 0, 0, 24'h0, 1);
        check("err_count_sat", err_count, 255);
        repeat (3) cycle(0, 0, 0, 0, 24'h0, 1);

        cycle(1, 0, 0, 0, 24'h000011, 0);
        cycle(1, 0, 0, 0, 24'h000022, 0);
        check("full_in_ready", in_ready, 0);
        cycle(1, 0, 0, 0, 24'h000033, 0);
        check("full_ignored", last_acc, 0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle(1, 0, 0, 0, 24'h000033, 1);
            got = last_acc;
        end
        check("release_accept", got, 1);
        repeat (3) cycle(0, 0, 0, 0, 24'h0, 1);

        for (int i = 0; i < 20; i++) begin
            cycle(1, $urandom_range(0, 2), $urandom_range(0, 15), 1'($urandom), 24'($urandom), 1);
            check("stream_accept", last_acc, 1);
        end

        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 15), 1'($urandom),
                  24'($urandom), $urandom_range(0, 3) != 0);
        end

        repeat (3) cycle(0, 0, 0, 0, 24'h0, 1);
        cycle(1, 3, 0, 0, 24'h0000AA, 0);
        cycle(1, 0, 0, 0, 24'h0000BB, 0);
        @(negedge clk);
        mon_en = 1'b0;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_err_count", err_count, 0);
        exp_q.delete();
        exp_errs = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (5) cycle(0, 0, 0, 0, 24'h0, 1);
        check("stale_out_valid", out_valid, 0);
        check("drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
